// File: rtl/window_sequencer.sv
// Frame sequencer for the Hamming-window multiply path: coefficient table, sample
// handshake, frame marking and counting. Define WINDOW_SEQ_ROUND_EN for rounded output.
module window_sequencer #(
  parameter int SIZE = 8,
  parameter int IDXW = $clog2(SIZE),
  parameter int FCW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_addr,
  input  logic [6:0]      cfg_data,
  output logic            cfg_err,
  input  logic            start,
  input  logic            stop,
  output logic            busy,
  input  logic            in_valid,
  input  logic [6:0]      in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [6:0]      out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic [FCW-1:0]  frame_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            out_valid_q, out_valid_d;
  logic [6:0]      out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;

  logic [6:0]      coef_tab [SIZE];
  logic [6:0]      coef_rd;
  logic [13:0]     product;
  logic [6:0]      scaled;
  logic            accept;
  logic            last_idx;
  logic            out_xfer;
  logic            cfg_ok;

  assign cfg_ok = cfg_we && (state_q == ST_IDLE);

  // One register per table entry so the whole table can return to 127 on reset.
  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_coef
      logic [6:0] entry_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= 7'd127;
        end else if (cfg_ok && (cfg_addr == IDXW'(gi))) begin
          entry_q <= cfg_data;
        end
      end
      assign coef_tab[gi] = entry_q;
    end
  endgenerate

  assign coef_rd  = coef_tab[idx_q];
  assign product  = {7'd0, coef_rd} * {7'd0, in_data};
  assign in_ready = ((state_q == ST_RUN) || (state_q == ST_STOPPING)) &&
                    (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_idx = (idx_q == IDXW'(SIZE - 1));
  assign out_xfer = out_valid_q && out_ready;

`ifdef WINDOW_SEQ_ROUND_EN
  logic [14:0] rounded;
  assign rounded = {1'b0, product} + 15'd64;
  assign scaled  = (rounded[14:7] > 8'd127) ? 7'd127 : rounded[13:7];
`else
  assign scaled = product[13:7];
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = scaled;
      out_last_d  = last_idx;
      idx_d       = idx_q + IDXW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (out_xfer && out_last_q) begin
      frame_cnt_d = frame_cnt_q + FCW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          if (idx_q == '0) begin
            state_d = ST_DRAIN;
          end else if (accept && last_idx) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_STOPPING;
          end
        end
      end
      ST_STOPPING: begin
        if (accept && last_idx) begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        // Leave once the output register is empty or its last beat moves now.
        if (!out_valid_q || out_ready) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 7'd0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign cfg_err   = cfg_we && (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_window_sequencer.sv
// Directed bench for window_sequencer with hand-computed expectations.
module tb_window_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [6:0]  cfg_data;
  logic        cfg_err;
  logic        start;
  logic        stop;
  logic        busy;
  logic        in_valid;
  logic [6:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [6:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [15:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] tbl     [8] = '{7'd0, 7'd16, 7'd64, 7'd127, 7'd127, 7'd64, 7'd16, 7'd0};
  logic [6:0] win_exp [8] = '{7'd0, 7'd15, 7'd63, 7'd126, 7'd126, 7'd63, 7'd15, 7'd0};

  window_sequencer #(.SIZE(8), .IDXW(3), .FCW(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .start(start), .stop(stop), .busy(busy),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample, confirm it is taken, then check the registered result.
  task automatic beat(input string tg, input logic [6:0] d, input logic [6:0] eo, input logic el);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check({tg, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check({tg, "_vld"}, 32'(out_valid), 32'd1);
    check({tg, "_dat"}, 32'(out_data), 32'(eo));
    check({tg, "_lst"}, 32'(out_last), 32'(el));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovld", 32'(out_valid), 32'd0);
    check("rst_odat", 32'(out_data), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_rdy",  32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();

    // 1: default table, 100 -> 99
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_pre_vld", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) beat($sformatf("t1_b%0d", i), 7'd100, 7'd99, i == 7);
    in_valid = 1'b0; tick();
    check("t1_fcnt", 32'(frame_cnt), 32'd1);
    check("t1_drop", 32'(out_valid), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t1_drain", 32'(busy), 32'd1);
    tick();
    check("t1_idle", 32'(busy), 32'd0);

    // 2: program the window; last write shares the cycle with start
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = tbl[i];
      start = (i == 7);
      @(negedge clk);
      if (i == 0) check("t2_cfgerr", 32'(cfg_err), 32'd0);
      tick();
    end
    cfg_we = 1'b0; start = 1'b0;
    for (int i = 0; i < 8; i++) beat($sformatf("t2_b%0d", i), 7'd127, win_exp[i], i == 7);
    in_valid = 1'b0; tick();
    check("t2_fcnt", 32'(frame_cnt), 32'd2);

    // 3: downstream stall mid-frame
    for (int i = 0; i < 3; i++) beat($sformatf("t3_b%0d", i), 7'd127, win_exp[i], 1'b0);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t3_st%0d_rdy", k), 32'(in_ready), 32'd0);
      check($sformatf("t3_st%0d_dat", k), 32'(out_data), 32'd63);
      check($sformatf("t3_st%0d_vld", k), 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 3; i < 8; i++) beat($sformatf("t3_b%0d", i), 7'd127, win_exp[i], i == 7);
    in_valid = 1'b0; tick();
    check("t3_fcnt", 32'(frame_cnt), 32'd3);

    // 5: write rejected while running
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 7'd0;
    @(negedge clk);
    check("t5_err_on", 32'(cfg_err), 32'd1);
    tick(); cfg_we = 1'b0;
    @(negedge clk);
    check("t5_err_off", 32'(cfg_err), 32'd0);
    tick();

    // 4: stop after three samples; coef[2] must still be 64
    for (int i = 0; i < 3; i++) beat($sformatf("t4_b%0d", i), 7'd127, win_exp[i], 1'b0);
    in_valid = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    check("t4_stopping_busy", 32'(busy), 32'd1);
    for (int i = 3; i < 8; i++) beat($sformatf("t4_b%0d", i), 7'd127, win_exp[i], i == 7);
    @(negedge clk);
    check("t4_drain_rdy", 32'(in_ready), 32'd0);
    check("t4_drain_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_ovld", 32'(out_valid), 32'd0);
    check("t4_fcnt", 32'(frame_cnt), 32'd4);
    in_valid = 1'b0;

    // start+stop together, then stop coinciding with the last accept
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("t7_run", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) beat($sformatf("t7_b%0d", i), 7'd127, win_exp[i], 1'b0);
    stop = 1'b1;
    beat("t7_b7", 7'd127, win_exp[7], 1'b1);
    stop = 1'b0;
    @(negedge clk);
    check("t7_drain_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("t7_idle", 32'(busy), 32'd0);
    check("t7_fcnt", 32'(frame_cnt), 32'd5);
    in_valid = 1'b0;

    // 6: asynchronous reset at idx 5
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) beat($sformatf("t6_b%0d", i), 7'd127, win_exp[i], 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_ovld", 32'(out_valid), 32'd0);
    check("t6_odat", 32'(out_data), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_fcnt", 32'(frame_cnt), 32'd0);
    check("t6_rdy",  32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) beat($sformatf("t6_post_b%0d", i), 7'd100, 7'd99, 1'b0);
    in_valid = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
